// File: rtl/sva_consec_rep_checker.sv
// Hardware monitor for `$rose(sig) |-> sig[*MIN:MAX]` on NCH independent channels,
// with first-match/exact-run modes and a saturating fail counter. Macro SVA_CONSEC_REP_STICKY_EN adds err_sticky/err_chan.
module sva_consec_rep_checker #(
   parameter int NCH   = 2,
   parameter int MIN   = 3,
   parameter int MAX   = 3,
   parameter int MODE  = 0,
   parameter int CNT_W = 8,
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [NCH-1:0]   sig,
   output logic [NCH-1:0]   pass_o,
   output logic [NCH-1:0]   fail_o,
   output logic [NCH-1:0]   active_o,
   output logic [CNT_W-1:0] fail_count
`ifdef SVA_CONSEC_REP_STICKY_EN
   ,
   output logic             err_sticky,
   output logic [CH_W-1:0]  err_chan
`endif
);

   localparam int CW = $clog2(MAX + 1) + 1;
   localparam int FW = $clog2(NCH + 1);
   localparam int SW = CNT_W + FW;
   localparam logic [CW-1:0] MIN_C = CW'(MIN);
   localparam logic [CW-1:0] MAX_C = CW'(MAX);
   localparam logic [SW-1:0] SAT_C = SW'({CNT_W{1'b1}});

   if (MIN < 1) begin : g_bad_min
      $error("sva_consec_rep_checker: MIN must be >= 1");
   end
   if (MAX < MIN) begin : g_bad_max
      $error("sva_consec_rep_checker: MAX must be >= MIN");
   end
   if (MODE != 0 && MODE != 1) begin : g_bad_mode
      $error("sva_consec_rep_checker: MODE must be 0 or 1");
   end

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e           state_q [NCH];
   state_e           state_d [NCH];
   logic [CW-1:0]    cnt_q   [NCH];
   logic [CW-1:0]    cnt_d   [NCH];
   logic [NCH-1:0]   prev_q;
   logic [NCH-1:0]   pass_q, pass_d;
   logic [NCH-1:0]   fail_q, fail_d;
   logic [CNT_W-1:0] fail_count_q, fail_count_d;
   logic [FW-1:0]    nfail;
   logic [SW-1:0]    sum;

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         pass_d[i]  = 1'b0;
         fail_d[i]  = 1'b0;
         if (!en) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
         end else begin
            case (state_q[i])
               S_IDLE: begin
                  if (sig[i] && !prev_q[i]) begin
                     if (MIN == 1 && MODE == 0) begin
                        pass_d[i] = 1'b1;
                     end else begin
                        state_d[i] = S_RUN;
                        cnt_d[i]   = CW'(1);
                     end
                  end
               end
               S_RUN: begin
                  if (MODE == 0) begin
                     if (sig[i]) begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                        if (cnt_q[i] + CW'(1) == MIN_C) begin
                           pass_d[i]  = 1'b1;
                           state_d[i] = S_IDLE;
                        end
                     end else begin
                        fail_d[i]  = 1'b1;
                        state_d[i] = S_IDLE;
                     end
                  end else begin
                     // Exact-run: the run is judged when sig falls, or rejected as soon as it overruns MAX.
                     if (sig[i]) begin
                        if (cnt_q[i] + CW'(1) <= MAX_C) begin
                           cnt_d[i] = cnt_q[i] + CW'(1);
                        end else begin
                           fail_d[i]  = 1'b1;
                           state_d[i] = S_IDLE;
                        end
                     end else begin
                        pass_d[i]  = (cnt_q[i] >= MIN_C);
                        fail_d[i]  = (cnt_q[i] <  MIN_C);
                        state_d[i] = S_IDLE;
                     end
                  end
               end
               default: state_d[i] = S_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      nfail = '0;
      for (int i = 0; i < NCH; i++) begin
         nfail = nfail + FW'(fail_d[i]);
      end
      sum          = SW'(fail_count_q) + SW'(nfail);
      fail_count_d = (sum > SAT_C) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= S_IDLE;
            cnt_q[i]   <= '0;
         end
         prev_q       <= '1;
         pass_q       <= '0;
         fail_q       <= '0;
         fail_count_q <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         prev_q       <= sig;
         pass_q       <= pass_d;
         fail_q       <= fail_d;
         fail_count_q <= fail_count_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         active_o[i] = (state_q[i] == S_RUN);
      end
   end

   assign pass_o     = pass_q;
   assign fail_o     = fail_q;
   assign fail_count = fail_count_q;

`ifdef SVA_CONSEC_REP_STICKY_EN
   logic            sticky_q, sticky_d;
   logic [CH_W-1:0] chan_q, chan_d;

   // Descending scan so the lowest failing index is the one recorded.
   always_comb begin
      sticky_d = sticky_q | (|fail_d);
      chan_d   = chan_q;
      if (!sticky_q) begin
         for (int i = NCH - 1; i >= 0; i--) begin
            if (fail_d[i]) chan_d = CH_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_q <= 1'b0;
         chan_q   <= '0;
      end else begin
         sticky_q <= sticky_d;
         chan_q   <= chan_d;
      end
   end

   assign err_sticky = sticky_q;
   assign err_chan   = chan_q;
`endif

endmodule

// File: doc/sva_consec_rep_checker.md
Name: sva_consec_rep_checker

Overview:
- Synthesizable RTL monitor that implements the property `$rose(sig) |-> sig[*MIN:MAX]` independently on NCH channels.
- It is the hardware counterpart of the SVA consecutive and range repetition checks.
- Used as an embedded checker in regression benches and in emulation builds, where SVA is not available.
- Adds two things the plain SVA form lacks: a selectable match mode and an aggregate saturating fail counter.

Parameters:
- NCH, 2: number of independent channels.
- MIN, 3: minimum number of consecutive high samples, counting the trigger sample. Must be ≥1.
- MAX, 3: maximum number of consecutive high samples. Must be ≥MIN. Used only when MODE=1.
- MODE, 0: 0 = first-match, pass as soon as MIN is reached; 1 = exact-run, the run length must land in [MIN,MAX].
- CNT_W, 8: width of the fail counter.

Ports:
- clk  in  1  sampling clock; all evaluation happens on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  evaluation enable; 0 abandons all attempts.
- sig  in  NCH  monitored signals.
- pass_o  out  NCH  one-cycle pulse: the attempt on that channel succeeded.
- fail_o  out  NCH  one-cycle pulse: the attempt on that channel failed.
- active_o  out  NCH  an attempt is in progress on that channel.
- fail_count  out  CNT_W  saturating total of fail events across all channels.

Behaviour:
- Reset (rst=1 at posedge):
  - all channels go to IDLE; cnt=0.
  - prev[i] is set to 1, so a signal that is already high out of reset does not trigger.
  - pass_o, fail_o, active_o and fail_count are all 0.
  - Reset mid-attempt discards the attempt; no pass or fail is reported.
- prev[i] is updated every non-reset cycle, regardless of en.
- Per channel: a 2-state FSM (IDLE, RUN) with counter cnt of width $clog2(MAX+1)+1.
- All outputs are registered. A pass or fail pulse appears in the cycle after the deciding posedge sample.
- Trigger: in IDLE with en=1, sig=1 and prev=0. This sample counts as repetition 1.
  - If MIN==1 and MODE=0: pass, stay IDLE.
  - If MIN==1 and MODE=1: go to RUN.
  - Otherwise: go to RUN with cnt=1.
- RUN, MODE=0:
  - sig=1: cnt+1. If cnt+1==MIN, pass and go to IDLE.
  - sig=0: fail, go to IDLE.
- RUN, MODE=1:
  - sig=1 and cnt+1≤MAX: increment cnt.
  - sig=1 and cnt+1>MAX: fail (overrun), go to IDLE.
  - sig=0: pass if cnt≥MIN, otherwise fail; go to IDLE.
- After an attempt ends while sig is still high, no new attempt starts until sig falls and rises again.
- active_o[i] is 1 exactly while the channel is in RUN (registered state).
- en=0: every channel is forced to IDLE with no pass or fail. Triggers are ignored while en=0.
- fail_count:
  - Each cycle it adds popcount of that cycle's fail events.
  - Saturates at 2^CNT_W−1 and never wraps.
  - Cleared only by rst.
- Simultaneous fails on several channels in one cycle are all counted.
- Elaboration must stop with $error when MIN<1, when MAX<MIN, or when MODE is not 0 or 1.

Optional Feature:
- Macro: SVA_CONSEC_REP_STICKY_EN.
- When defined, two extra outputs are added:
  - err_sticky (1 bit): set by any fail, cleared only by rst.
  - err_chan (max(1,$clog2(NCH)) bits): index of the first failing channel; the lowest index wins on a simultaneous first fail. Frozen once err_sticky=1.
- Both outputs reset to 0 and update in the same cycle as the matching fail_o pulse.
- When undefined, neither port exists and behaviour is otherwise identical.

Test Plan:
- Default config, ch0: sig low for cycles 0-1, high for samples 2-4, low at 5.
  → pass_o[0] pulses once, the cycle after sample 4. No fail. fail_count=0.
- Default config, ch0: high for samples 2-3, low at 4.
  → fail_o[0] pulses after sample 4. fail_count=1. active_o[0] is high through samples 2-3, then low.
- MODE=1, MIN=2, MAX=4:
  - ch1 high for samples 6-8, low at 9 → pass after sample 9.
  - ch1 high for 5 samples → fail after the 5th high sample; no new attempt until ch1 falls and rises again.
- Both channels fail in the same cycle → fail_count increments by 2.
  - CNT_W=2 with 5 fails total → fail_count=3 (saturated).
- sig high during and immediately after rst → no trigger.
  - Separately: rst asserted mid-RUN → no pulse, active_o=0.
  - en dropped mid-RUN → no pulse, active_o=0.
- With SVA_CONSEC_REP_STICKY_EN defined, ch1 fails, then ch0 fails later.
  → err_sticky=1 from the first fail; err_chan=1 and stays 1.
